// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: state encoding, opcode constants and select codes shared
// by the multicycle controller and its output decoder.
package multicycle_ctrl_pkg;
   typedef enum logic [3:0] {
      S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
      S_RWB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_IMMEX, S_IMMWB, S_TRAP
   } state_t;
   localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04;
   localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_ADDI = 6'h08, OP_SUBI = 6'h09;
   localparam logic [5:0] FN_JR = 6'h08;
   localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_ADDI = 3'd2, ALU_SUBI = 3'd3, ALU_RTYPE = 3'd4;
   localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2;
   localparam logic [1:0] M2R_ALU = 2'd0, M2R_MEM = 2'd1, M2R_PC = 2'd2;
   localparam logic [1:0] SRCB_REG = 2'd0, SRCB_4 = 2'd1, SRCB_IMM = 2'd2, SRCB_IMM_SH = 2'd3;
   localparam logic [1:0] PCS_ALU = 2'd0, PCS_ALU_OUT = 2'd1, PCS_JUMP = 2'd2, PCS_RS = 2'd3;
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ir_write;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [2:0] alu_op;
      logic       retire;
      logic       illegal;
   } ctrl_t;
endpackage

// File: rtl/multicycle_ctrl_decode.sv
// multicycle_ctrl_decode: state to control-strobe decode; mem_ready only gates
// the handshake-completion strobes in FETCH and MEMWR.
module multicycle_ctrl_decode
   import multicycle_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic       mem_ready,
   input  logic [5:0] opcode,
   output ctrl_t      ctrl
);
   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read = 1'b1;
            ctrl.alu_src_b = SRCB_4;
            ctrl.alu_op = ALU_ADD;
            ctrl.pc_source = PCS_ALU;
            ctrl.ir_write = mem_ready;
            ctrl.pc_write = mem_ready;
         end
         S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst = RD_RT;
            ctrl.mem_to_reg = M2R_MEM;
            ctrl.retire = 1'b1;
         end
         S_MEMWR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord = 1'b1;
            ctrl.retire = mem_ready;
         end
         S_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op = ALU_RTYPE;
         end
         S_RWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst = RD_RD;
            ctrl.mem_to_reg = M2R_ALU;
            ctrl.retire = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source = PCS_ALU_OUT;
            ctrl.retire = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_source = PCS_JUMP;
            ctrl.retire = 1'b1;
         end
         S_JAL: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_source = PCS_JUMP;
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst = RD_RA;
            ctrl.mem_to_reg = M2R_PC;
            ctrl.retire = 1'b1;
         end
         S_JR: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_source = PCS_RS;
            ctrl.retire = 1'b1;
         end
         S_IMMEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op = opcode == OP_SUBI ? ALU_SUBI : ALU_ADDI;
         end
         S_IMMWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst = RD_RT;
            ctrl.mem_to_reg = M2R_ALU;
            ctrl.retire = 1'b1;
         end
         S_TRAP: ctrl.illegal = 1'b1;
         default: ctrl = '0;
      endcase
   end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS-style control FSM; state register and
// next-state logic here, output decode in multicycle_ctrl_decode.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int ALUOP_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               ir_write,
   output logic               iord,
   output logic               mem_read,
   output logic               mem_write,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         reg_dst,
   output logic [1:0]         mem_to_reg,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         pc_source,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               retire,
   output logic               illegal,
   output logic [3:0]         state_o
);
   state_t state, next;
   logic armed;
   ctrl_t ctrl;
   // armed delays leaving RESET by one edge so FETCH starts on the second edge after release
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= S_RESET;
         armed <= 1'b0;
      end else begin
         state <= next;
         armed <= 1'b1;
      end
   always_comb begin
      next = state;
      case (state)
         S_RESET: next = armed ? S_FETCH : S_RESET;
         S_FETCH: next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:
            case (opcode)
               OP_LW, OP_SW: next = S_MEMADR;
               OP_R: next = funct == FN_JR ? S_JR : S_EXEC;
               OP_BEQ: next = S_BRANCH;
               OP_J: next = S_JUMP;
               OP_JAL: next = S_JAL;
               OP_ADDI, OP_SUBI: next = S_IMMEX;
               default: next = S_TRAP;
            endcase
         S_MEMADR: next = opcode == OP_SW ? S_MEMWR : S_MEMRD;
         S_MEMRD: next = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR: next = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC: next = S_RWB;
         S_IMMEX: next = S_IMMWB;
         S_TRAP: next = S_TRAP;
         default: next = S_FETCH;
      endcase
   end
   multicycle_ctrl_decode u_decode (
      .state(state),
      .mem_ready(mem_ready),
      .opcode(opcode),
      .ctrl(ctrl)
   );
   assign pc_write = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign ir_write = ctrl.ir_write;
   assign iord = ctrl.iord;
   assign mem_read = ctrl.mem_read;
   assign mem_write = ctrl.mem_write;
   assign reg_write = ctrl.reg_write;
   assign alu_src_a = ctrl.alu_src_a;
   assign reg_dst = ctrl.reg_dst;
   assign mem_to_reg = ctrl.mem_to_reg;
   assign alu_src_b = ctrl.alu_src_b;
   assign pc_source = ctrl.pc_source;
   assign alu_op = ALUOP_W'(ctrl.alu_op);
   assign retire = ctrl.retire;
   assign illegal = ctrl.illegal;
   assign state_o = state;
endmodule
